// File: rtl/hub75_scan.sv
// HUB75 scan driver for a 64x32, 1/16-scan panel.
// Reads pixel pairs (rows r and r+16) from the frame RAM, shifts them out one
// bit-plane at a time, latches, then lights the plane with binary-coded on-time.
module hub75_scan #(
    parameter int unsigned BITS_PER_PIXEL = 32,
    parameter int unsigned PLANES         = 8,
    parameter int unsigned BASE_TIME      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [9:0]                read_addr,
    output logic                      read_en,
    input  logic [BITS_PER_PIXEL-1:0] read_data_top,
    input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
    output logic                      hub75_clk,
    output logic                      hub75_lat,
    output logic                      hub75_oe,
    output logic [2:0]                hub75_rgb1,
    output logic [2:0]                hub75_rgb2,
    output logic [3:0]                hub75_addr,
    output logic                      frame_done
);

    localparam int unsigned MaxOn     = BASE_TIME << (PLANES - 1);
    localparam int unsigned CntW      = (MaxOn > 1) ? $clog2(MaxOn) : 1;
    localparam logic [2:0]  PlaneOfs  = 3'(8 - PLANES);
    localparam logic [2:0]  LastPlane = 3'(PLANES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [2:0] {
        StIdle, StPrefetch, StShift, StBlank, StLatch, StDisplay
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      row_q, row_d;
    logic [2:0]      plane_q, plane_d;
    logic [5:0]      col_q, col_d;
    logic            phase_q, phase_d;   // 0: L (shift clock low), 1: H
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [9:0]      read_addr_q, read_addr_d;
    logic            read_en_q, read_en_d;
    logic            hclk_q, hclk_d;
    logic            lat_q, lat_d;
    logic            oe_q, oe_d;
    logic [3:0]      haddr_q, haddr_d;
    logic            fdone_q, fdone_d;
    logic            rd_valid_q;
    logic [2:0]      rgb1_q, rgb2_q;
    logic [2:0]      bsel;

    if (BITS_PER_PIXEL > 24) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{read_data_top[BITS_PER_PIXEL-1:24],
                             read_data_bottom[BITS_PER_PIXEL-1:24]};
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        plane_d     = plane_q;
        col_d       = col_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        read_addr_d = read_addr_q;
        read_en_d   = 1'b0;
        hclk_d      = 1'b0;
        lat_d       = 1'b0;
        oe_d        = 1'b1;
        haddr_d     = haddr_q;
        fdone_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d     = StPrefetch;
                    col_d       = 6'd0;
                    read_en_d   = 1'b1;
                    read_addr_d = {row_q, 6'd0};
                end
            end
            StPrefetch: begin
                // First L phase of column 0 fetches column 1.
                state_d     = StShift;
                phase_d     = 1'b0;
                col_d       = 6'd0;
                read_en_d   = 1'b1;
                read_addr_d = {row_q, 6'd1};
            end
            StShift: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    hclk_d  = 1'b1;
                end else if (col_q == 6'd63) begin
                    state_d = StBlank;
                    phase_d = 1'b0;
                    col_d   = 6'd0;
                    haddr_d = row_q;
                end else begin
                    phase_d = 1'b0;
                    col_d   = col_q + 6'd1;
                    if (col_q != 6'd62) begin
                        read_en_d   = 1'b1;
                        read_addr_d = {row_q, col_q + 6'd2};
                    end
                end
            end
            StBlank: begin
                state_d = StLatch;
                lat_d   = 1'b1;
            end
            StLatch: begin
                state_d = StDisplay;
                oe_d    = 1'b0;
                cnt_d   = CntW'((BASE_TIME << plane_q) - 1);
            end
            StDisplay: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                    oe_d  = 1'b0;
                end else begin
                    state_d = StPrefetch;
                    if (plane_q != LastPlane) begin
                        plane_d = plane_q + 3'd1;
                    end else begin
                        plane_d = 3'd0;
                        if (row_q != 4'd15) begin
                            row_d = row_q + 4'd1;
                        end else begin
                            row_d   = 4'd0;
                            fdone_d = 1'b1;
                            // enable is only honoured at the frame wrap
                            if (!enable) state_d = StIdle;
                        end
                    end
                    if (state_d == StPrefetch) begin
                        col_d       = 6'd0;
                        read_en_d   = 1'b1;
                        read_addr_d = {row_d, 6'd0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan state and registered panel/RAM control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= 4'd0;
            plane_q     <= 3'd0;
            col_q       <= 6'd0;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            read_addr_q <= 10'd0;
            read_en_q   <= 1'b0;
            hclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_q        <= 1'b1;
            haddr_q     <= 4'd0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            plane_q     <= plane_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            read_addr_q <= read_addr_d;
            read_en_q   <= read_en_d;
            hclk_q      <= hclk_d;
            lat_q       <= lat_d;
            oe_q        <= oe_d;
            haddr_q     <= haddr_d;
            fdone_q     <= fdone_d;
        end
    end

    assign bsel = PlaneOfs + plane_q;

    // Capture the plane bits of each pixel the cycle its RAM data is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rgb1_q     <= 3'd0;
            rgb2_q     <= 3'd0;
        end else begin
            rd_valid_q <= read_en_q;
            if (rd_valid_q) begin
                rgb1_q <= {read_data_top[{2'b10, bsel}], read_data_top[{2'b01, bsel}],
                           read_data_top[{2'b00, bsel}]};
                rgb2_q <= {read_data_bottom[{2'b10, bsel}], read_data_bottom[{2'b01, bsel}],
                           read_data_bottom[{2'b00, bsel}]};
            end
        end
    end

    assign read_addr  = read_addr_q;
    assign read_en    = read_en_q;
    assign hub75_clk  = hclk_q;
    assign hub75_lat  = lat_q;
    assign hub75_oe   = oe_q;
    assign hub75_rgb1 = rgb1_q;
    assign hub75_rgb2 = rgb2_q;
    assign hub75_addr = haddr_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_hub75_scan.sv
// Scoreboard bench for hub75_scan: expected RAM reads, shifted pixels, latch rows,
// on-times and frame periods are queued up front and consumed by a monitor.
module tb_hub75_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [31:0] read_data_top;
    logic [31:0] read_data_bottom;
    logic        hub75_clk, hub75_lat, hub75_oe, frame_done;
    logic [2:0]  hub75_rgb1, hub75_rgb2;
    logic [3:0]  hub75_addr;

    hub75_scan #(
        .BITS_PER_PIXEL(32),
        .PLANES        (8),
        .BASE_TIME     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .read_addr       (read_addr),
        .read_en         (read_en),
        .read_data_top   (read_data_top),
        .read_data_bottom(read_data_bottom),
        .hub75_clk       (hub75_clk),
        .hub75_lat       (hub75_lat),
        .hub75_oe        (hub75_oe),
        .hub75_rgb1      (hub75_rgb1),
        .hub75_rgb2      (hub75_rgb2),
        .hub75_addr      (hub75_addr),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    // Rows 0..7: even columns pure red on top, odd pure blue; bottom pure green.
    // Rows 8..15: distinct per-bit patterns so each plane selects different bits.
    function automatic logic [31:0] top_word(input logic [9:0] a);
        if (a[9] == 1'b0) return a[0] ? 32'h000000FF : 32'h00FF0000;
        return a[0] ? 32'hFF5AF0C3 : 32'h00A50F3C;
    endfunction

    function automatic logic [31:0] bot_word(input logic [9:0] a);
        if (a[9] == 1'b0) return 32'h0000FF00;
        return a[0] ? 32'hAA7EBDDB : 32'h00814224;
    endfunction

    function automatic logic [5:0] exp_pix(input int r, input int p, input int c);
        logic [9:0]  a;
        logic [31:0] t, b;
        a = {r[3:0], c[5:0]};
        t = top_word(a);
        b = bot_word(a);
        return {t[16+p], t[8+p], t[p], b[16+p], b[8+p], b[p]};
    endfunction

    // Frame RAM model: one cycle read latency.
    always @(posedge clk) begin
        if (read_en) begin
            read_data_top    <= top_word(read_addr);
            read_data_bottom <= bot_word(read_addr);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got event/timeout, expected none", name);
    endtask

    logic [9:0] addr_sb[$];
    logic [5:0] pix_sb[$];
    int         oe_sb[$];
    logic [3:0] row_sb[$];
    int         period_sb[$];

    logic sb_on = 1'b0;
    int   cyc = 0;
    int   oe_run = 0;
    int   fd_count = 0;
    int   last_fd = 0;
    logic prev_hclk = 1'b0;
    logic prev_lat = 1'b0;
    logic prev_fd = 1'b0;

    // Monitor: samples on the falling edge and pops whenever the DUT presents an event.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sb_on) begin
            if (hub75_clk && !prev_hclk) begin
                if (pix_sb.size() == 0) fail("pix_extra");
                else check("pix_rgb", {26'd0, hub75_rgb1, hub75_rgb2}, {26'd0, pix_sb.pop_front()});
            end
            if (read_en) begin
                if (addr_sb.size() == 0) fail("read_extra");
                else check("read_addr", {22'd0, read_addr}, {22'd0, addr_sb.pop_front()});
            end
            if (!hub75_oe) begin
                oe_run++;
            end else if (oe_run > 0) begin
                if (oe_sb.size() == 0) fail("oe_extra");
                else check("oe_low_len", oe_run, oe_sb.pop_front());
                oe_run = 0;
            end
            if (hub75_lat) begin
                if (prev_lat) fail("lat_width");
                else if (row_sb.size() == 0) fail("lat_extra");
                else check("lat_row", {28'd0, hub75_addr}, {28'd0, row_sb.pop_front()});
            end
            if (frame_done) begin
                if (prev_fd) begin
                    fail("frame_done_width");
                end else begin
                    if (fd_count > 0) begin
                        if (period_sb.size() == 0) fail("frame_done_extra");
                        else check("frame_period", cyc - last_fd, period_sb.pop_front());
                    end
                    fd_count++;
                    last_fd = cyc;
                end
            end
        end
        prev_hclk = hub75_clk;
        prev_lat  = hub75_lat;
        prev_fd   = frame_done;
    end

    int guard;
    int bad;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_addr", {22'd0, read_addr}, 32'd0);
        check("rst_read_en", {31'd0, read_en}, 32'd0);
        check("rst_hclk", {31'd0, hub75_clk}, 32'd0);
        check("rst_lat", {31'd0, hub75_lat}, 32'd0);
        check("rst_oe", {31'd0, hub75_oe}, 32'd1);
        check("rst_rgb", {26'd0, hub75_rgb1, hub75_rgb2}, 32'd0);
        check("rst_haddr", {28'd0, hub75_addr}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);

        reset = 1'b0;
        sb_on = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_oe", {31'd0, hub75_oe}, 32'd1);

        // Two full frames of expectations.
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 16; r++) begin
                for (int p = 0; p < 8; p++) begin
                    row_sb.push_back(4'(r));
                    oe_sb.push_back(4 << p);
                    for (int c = 0; c < 64; c++) begin
                        addr_sb.push_back({4'(r), 6'(c)});
                        pix_sb.push_back(exp_pix(r, p, c));
                    end
                end
            end
        end
        period_sb.push_back(33088);

        enable = 1'b1;
        guard = 0;
        while (fd_count < 1 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (fd_count < 1) fail("timeout_frame1");

        // Drop enable during row 5 of the second frame; the frame must still complete.
        guard = 0;
        while (hub75_addr != 4'd5 && guard < 15000) begin
            @(negedge clk);
            guard++;
        end
        if (hub75_addr != 4'd5) fail("timeout_row5");
        enable = 1'b0;

        guard = 0;
        while (fd_count < 2 && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (fd_count < 2) fail("timeout_frame2");

        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (read_en || !hub75_oe) bad++;
        end
        check("idle_after_frame", bad, 0);
        check("addr_sb_drained", addr_sb.size(), 0);
        check("pix_sb_drained", pix_sb.size(), 0);
        check("oe_sb_drained", oe_sb.size(), 0);
        check("row_sb_drained", row_sb.size(), 0);
        check("period_sb_drained", period_sb.size(), 0);
        check("frame_done_count", fd_count, 2);

        // Asynchronous reset in the middle of a shift.
        sb_on  = 1'b0;
        enable = 1'b1;
        guard  = 0;
        while (!hub75_clk && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!hub75_clk) fail("timeout_shift");
        #2;
        reset = 1'b1;
        #1;
        check("async_oe", {31'd0, hub75_oe}, 32'd1);
        check("async_hclk", {31'd0, hub75_clk}, 32'd0);
        check("async_lat", {31'd0, hub75_lat}, 32'd0);
        check("async_read_en", {31'd0, read_en}, 32'd0);
        check("async_read_addr", {22'd0, read_addr}, 32'd0);
        check("async_haddr", {28'd0, hub75_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        guard = 0;
        while (!read_en && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!read_en) fail("timeout_restart");
        check("restart_addr0", {22'd0, read_addr}, 32'd0);
        @(negedge clk);
        check("restart_addr1", {22'd0, read_addr}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
